// File: rtl/vec_mem_arbiter.sv
// vec_mem_arbiter: shares one native-protocol memory between the CPU port and
// the vector coprocessor port. Round-robin grant, byte-address range check and
// a response watchdog. Responses are returned combinationally in the cycle the
// slave answers; an idle cycle always separates two grants.
module vec_mem_arbiter #(
  parameter logic [31:0] ADDR_LIMIT = 32'd1024,
  parameter logic [15:0] TIMEOUT    = 16'd64,
  parameter logic [31:0] ERR_RDATA  = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        cpu_mem_valid,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_wdata,
  input  logic [3:0]  cpu_mem_wstrb,
  output logic        cpu_mem_ready,
  output logic [31:0] cpu_mem_rdata,

  input  logic        vec_mem_valid,
  input  logic [31:0] vec_mem_addr,
  input  logic [31:0] vec_mem_wdata,
  input  logic [3:0]  vec_mem_wstrb,
  output logic        vec_mem_ready,
  output logic [31:0] vec_mem_rdata,

  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,

  output logic        bus_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_ERR
  } state_t;

  typedef enum logic {
    M_CPU,
    M_VEC
  } master_t;

  state_t      state;
  state_t      state_nxt;
  master_t     owner;
  master_t     last;
  master_t     win;

  logic        grant;
  logic        in_range;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic [3:0]  win_wstrb;

  logic [15:0] wd_cnt;
  logic        timeout_hit;

  logic        resp;
  logic        resp_err;
  logic [31:0] resp_rdata;

  // Arbitration: a lone requester wins; a tie goes to the master not served last.
  always_comb begin
    grant = cpu_mem_valid | vec_mem_valid;
    win   = M_CPU;
    if (cpu_mem_valid && vec_mem_valid) begin
      win = (last == M_CPU) ? M_VEC : M_CPU;
    end else if (vec_mem_valid) begin
      win = M_VEC;
    end
    if (win == M_VEC) begin
      win_addr  = vec_mem_addr;
      win_wdata = vec_mem_wdata;
      win_wstrb = vec_mem_wstrb;
    end else begin
      win_addr  = cpu_mem_addr;
      win_wdata = cpu_mem_wdata;
      win_wstrb = cpu_mem_wstrb;
    end
    in_range = (win_addr < ADDR_LIMIT);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and response generation. The watchdog fires once the counter,
  // which is zero in the first ISSUE cycle, has counted TIMEOUT cycles; a
  // simultaneous mem_ready takes priority over the timeout.
  always_comb begin
    state_nxt   = state;
    resp        = 1'b0;
    resp_err    = 1'b0;
    resp_rdata  = '0;
    timeout_hit = (TIMEOUT != '0) && (wd_cnt == TIMEOUT);
    unique case (state)
      S_IDLE: begin
        if (grant) begin
          state_nxt = in_range ? S_ISSUE : S_ERR;
        end
      end
      S_ISSUE: begin
        if (mem_ready) begin
          resp       = 1'b1;
          resp_rdata = mem_rdata;
          state_nxt  = S_IDLE;
        end else if (timeout_hit) begin
          resp       = 1'b1;
          resp_err   = 1'b1;
          resp_rdata = ERR_RDATA;
          state_nxt  = S_IDLE;
        end
      end
      S_ERR: begin
        resp       = 1'b1;
        resp_err   = 1'b1;
        resp_rdata = ERR_RDATA;
        state_nxt  = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Request registers, grant bookkeeping and the watchdog counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner     <= M_CPU;
      last      <= M_VEC;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      wd_cnt    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (grant) begin
            owner     <= win;
            last      <= win;
            mem_addr  <= win_addr;
            mem_wdata <= win_wdata;
            mem_wstrb <= win_wstrb;
            mem_valid <= in_range;
            wd_cnt    <= '0;
          end
        end
        S_ISSUE: begin
          wd_cnt <= wd_cnt + 16'd1;
          if (resp) begin
            mem_valid <= 1'b0;
          end
        end
        default: begin
          mem_valid <= 1'b0;
        end
      endcase
    end
  end

  // Steer the response to the owner; the other master sees ready=0, rdata=0.
  always_comb begin
    cpu_mem_ready = 1'b0;
    cpu_mem_rdata = '0;
    vec_mem_ready = 1'b0;
    vec_mem_rdata = '0;
    bus_err       = resp_err;
    if (resp) begin
      if (owner == M_VEC) begin
        vec_mem_ready = 1'b1;
        vec_mem_rdata = resp_rdata;
      end else begin
        cpu_mem_ready = 1'b1;
        cpu_mem_rdata = resp_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vec_mem_arbiter.sv
// Bench for vec_mem_arbiter: directed requests from both masters against a
// small memory model; expected responses go into a scoreboard queue and a
// monitor compares every response the arbiter presents.
module tb_vec_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_mem_valid;
  logic [31:0] cpu_mem_addr;
  logic [31:0] cpu_mem_wdata;
  logic [3:0]  cpu_mem_wstrb;
  logic        cpu_mem_ready;
  logic [31:0] cpu_mem_rdata;
  logic        vec_mem_valid;
  logic [31:0] vec_mem_addr;
  logic [31:0] vec_mem_wdata;
  logic [3:0]  vec_mem_wstrb;
  logic        vec_mem_ready;
  logic [31:0] vec_mem_rdata;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        bus_err;

  vec_mem_arbiter #(
    .ADDR_LIMIT (32'd1024),
    .TIMEOUT    (16'd8),
    .ERR_RDATA  (32'hDEADBEEF)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_mem_valid (cpu_mem_valid),
    .cpu_mem_addr  (cpu_mem_addr),
    .cpu_mem_wdata (cpu_mem_wdata),
    .cpu_mem_wstrb (cpu_mem_wstrb),
    .cpu_mem_ready (cpu_mem_ready),
    .cpu_mem_rdata (cpu_mem_rdata),
    .vec_mem_valid (vec_mem_valid),
    .vec_mem_addr  (vec_mem_addr),
    .vec_mem_wdata (vec_mem_wdata),
    .vec_mem_wstrb (vec_mem_wstrb),
    .vec_mem_ready (vec_mem_ready),
    .vec_mem_rdata (vec_mem_rdata),
    .mem_valid     (mem_valid),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .bus_err       (bus_err)
  );

  typedef struct {
    bit          vec;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [0:255];
  bit          slave_mute;
  int          valid_cycles;
  int          n_chk;
  int          n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_resp(input bit vec, input logic [31:0] rdata, input bit err);
    exp_t e;
    e.vec   = vec;
    e.rdata = rdata;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the edge that closed the response.
  task automatic req(input bit vec, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] ws, input bit release_v);
    int n;
    bit got;
    if (vec) begin
      vec_mem_valid = 1'b1;
      vec_mem_addr  = a;
      vec_mem_wdata = wd;
      vec_mem_wstrb = ws;
    end else begin
      cpu_mem_valid = 1'b1;
      cpu_mem_addr  = a;
      cpu_mem_wdata = wd;
      cpu_mem_wstrb = ws;
    end
    n   = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      #1;
      n++;
      got = vec ? vec_mem_ready : cpu_mem_ready;
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL req_timeout: no ready for %s addr %h after %0d cycles", vec ? "vec" : "cpu", a, n);
    end
    @(posedge clk);
    #1;
    if (release_v) begin
      if (vec) vec_mem_valid = 1'b0;
      else     cpu_mem_valid = 1'b0;
    end
  endtask

  // Memory model: answers an outstanding request at the negedge of its first ISSUE cycle.
  initial begin
    logic [7:0] idx;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ready) begin
        mem_ready = 1'b0;
        mem_rdata = '0;
      end else if (mem_valid && !slave_mute) begin
        idx = mem_addr[9:2];
        if (mem_wstrb != 4'b0000) begin
          for (int b = 0; b < 4; b++) begin
            if (mem_wstrb[b]) mem[idx][8*b +: 8] = mem_wdata[8*b +: 8];
          end
          mem_rdata = '0;
        end else begin
          mem_rdata = mem[idx];
        end
        mem_ready = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mem_valid) valid_cycles++;
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t        e;
    bit          m;
    logic [31:0] rd;
    logic [31:0] other;
    forever begin
      @(negedge clk);
      #1;
      if (cpu_mem_ready || vec_mem_ready) begin
        if (cpu_mem_ready && vec_mem_ready) begin
          n_chk++;
          n_fail++;
          $display("FAIL both_ready: cpu and vec ready together at %0t", $time);
        end else if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_ready: cpu=%b vec=%b rdata=%h/%h at %0t",
                   cpu_mem_ready, vec_mem_ready, cpu_mem_rdata, vec_mem_rdata, $time);
        end else begin
          e     = exp_q.pop_front();
          m     = vec_mem_ready;
          rd    = m ? vec_mem_rdata : cpu_mem_rdata;
          other = m ? cpu_mem_rdata : vec_mem_rdata;
          chk("resp_master(1=vec)", 32'(m), 32'(e.vec));
          chk("resp_rdata", rd, e.rdata);
          chk("resp_bus_err", 32'(bus_err), 32'(e.err));
          chk("nonowner_rdata", other, 32'h0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    bit seen;
    n_chk = 0;
    n_fail = 0;
    valid_cycles = 0;
    slave_mute = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
    mem[100] = 32'h0201_0201;   // 0x190
    mem[109] = 32'hAABB_CCDD;   // 0x1B4
    reset = 1'b1;
    cpu_mem_valid = 1'b0; cpu_mem_addr = '0; cpu_mem_wdata = '0; cpu_mem_wstrb = '0;
    vec_mem_valid = 1'b0; vec_mem_addr = '0; vec_mem_wdata = '0; vec_mem_wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_valid", 32'(mem_valid), 32'h0);
    chk("rst_cpu_ready", 32'(cpu_mem_ready), 32'h0);
    chk("rst_vec_ready", 32'(vec_mem_ready), 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // CPU-only read.
    expect_resp(1'b0, 32'h0201_0201, 1'b0);
    req(1'b0, 32'h190, 32'h0, 4'b0000, 1'b1);

    // Ties from reset: C,V,C,V,C,V.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    expect_resp(1'b0, 32'hA500_0004, 1'b0);
    expect_resp(1'b1, 32'hA500_0008, 1'b0);
    expect_resp(1'b0, 32'hA500_0005, 1'b0);
    expect_resp(1'b1, 32'hA500_0009, 1'b0);
    expect_resp(1'b0, 32'hA500_0006, 1'b0);
    expect_resp(1'b1, 32'hA500_000A, 1'b0);
    fork
      begin
        req(1'b0, 32'h10, 32'h0, 4'b0000, 1'b0);
        req(1'b0, 32'h14, 32'h0, 4'b0000, 1'b0);
        req(1'b0, 32'h18, 32'h0, 4'b0000, 1'b1);
      end
      begin
        req(1'b1, 32'h20, 32'h0, 4'b0000, 1'b0);
        req(1'b1, 32'h24, 32'h0, 4'b0000, 1'b0);
        req(1'b1, 32'h28, 32'h0, 4'b0000, 1'b1);
      end
    join

    // Partial vec write, then read back through the CPU.
    expect_resp(1'b1, 32'h0, 1'b0);
    req(1'b1, 32'h1B4, 32'h1122_3344, 4'b0011, 1'b1);
    chk("wr_mem_word", mem[109], 32'hAABB_3344);
    expect_resp(1'b0, 32'hAABB_3344, 1'b0);
    req(1'b0, 32'h1B4, 32'h0, 4'b0000, 1'b1);

    // Range boundary: 0x400 rejected without a slave access, 0x3FC served.
    valid_cycles = 0;
    expect_resp(1'b1, 32'hDEAD_BEEF, 1'b1);
    req(1'b1, 32'h400, 32'h0, 4'b0000, 1'b1);
    chk("oor_mem_valid_cycles", 32'(valid_cycles), 32'h0);
    expect_resp(1'b0, 32'hA500_00FF, 1'b0);
    req(1'b0, 32'h3FC, 32'h0, 4'b0000, 1'b1);

    // Watchdog: silent slave for the CPU access, vec served afterwards.
    slave_mute = 1'b1;
    expect_resp(1'b0, 32'hDEAD_BEEF, 1'b1);
    expect_resp(1'b1, 32'hA500_000C, 1'b0);
    fork
      req(1'b0, 32'h40, 32'h0, 4'b0000, 1'b1);
      begin
        repeat (2) @(posedge clk);
        #1;
        req(1'b1, 32'h30, 32'h0, 4'b0000, 1'b1);
      end
      begin
        seen = 1'b0;
        n = 0;
        while (!seen && n < 50) begin
          @(negedge clk);
          #1;
          seen = mem_valid;
          n++;
        end
        n = 0;
        seen = 1'b0;
        while (!seen && n < 50) begin
          @(negedge clk);
          #1;
          n++;
          seen = cpu_mem_ready;
        end
        chk("timeout_latency", 32'(n), 32'd8);
        slave_mute = 1'b0;
      end
    join

    // Reset during ISSUE aborts the access; the next tie goes to the CPU.
    slave_mute = 1'b1;
    cpu_mem_valid = 1'b1;
    cpu_mem_addr  = 32'h50;
    cpu_mem_wdata = 32'h0;
    cpu_mem_wstrb = 4'b0000;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 50) begin
      @(negedge clk);
      #1;
      seen = mem_valid;
      n++;
    end
    chk("abort_issue_reached", 32'(seen), 32'h1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_mem_valid", 32'(mem_valid), 32'h0);
    chk("abort_cpu_ready", 32'(cpu_mem_ready), 32'h0);
    chk("abort_vec_ready", 32'(vec_mem_ready), 32'h0);
    cpu_mem_valid = 1'b0;
    reset = 1'b0;
    slave_mute = 1'b0;
    expect_resp(1'b0, 32'hA500_0018, 1'b0);
    expect_resp(1'b1, 32'hA500_0019, 1'b0);
    fork
      req(1'b0, 32'h60, 32'h0, 4'b0000, 1'b1);
      req(1'b1, 32'h64, 32'h0, 4'b0000, 1'b1);
    join

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
